rally_ctrl: RTL and testbench
=============================

# rally_ctrl

Rally/score controller that produces `Game_state` and `who_win` for the ball physics block and consumes its `Ball_X`/`Ball_Y`. It detects when the ball touches the floor, decides which side it landed on, updates both scores, and sequences START → WAIT (serve delay) → PLAY → WAIT … → END. The scores and point pulse also drive the display and sound logic.

## Interface
Parameters:
- `BALL_W`, 30, ball sprite width in pixels
- `BALL_H`, 30, ball sprite height in pixels
- `FLOOR_Y`, 220, floor line; the ball has landed when `Ball_Y + BALL_H >= FLOOR_Y`
- `NET_X`, 160, left edge of net; it splits the court into the NPC half (left) and the player half (right)
- `WIN_SCORE`, 5, score that ends the match
- `WAIT_CYCLES`, 50_000_000, serve delay in WAIT state (1 s at 50 MHz)
- `ARM_CYCLES`, 2, PLAY cycles before floor detection is enabled

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `start_btn`  in  1  start request, already synchronized to `clk`, level
- `Ball_X`  in  12  ball top-left x from ball block
- `Ball_Y`  in  12  ball top-left y from ball block
- `Game_state`  out  2  0 START, 1 WAIT, 2 PLAY, 3 END (registered)
- `who_win`  out  1  winner of last point: 0 player, 1 NPC (registered)
- `player_score`  out  4  player points, 0..WIN_SCORE
- `npc_score`  out  4  NPC points, 0..WIN_SCORE
- `point_pulse`  out  1  one-cycle pulse on each scored point

## Operation
- Reset (async, `reset_n`=0): `Game_state`=0, `who_win`=0, both scores 0, `point_pulse`=0, wait counter 0, arm counter 0, `start_prev`=0.
- Start edge: `start_edge = start_btn & ~start_prev`. `start_prev` is registered every cycle. A held button produces exactly one edge.
- START (0):
  - Scores are held at 0 and `who_win` at 0.
  - `start_edge` moves to WAIT.
- WAIT (1):
  - The wait counter clears on entry and counts up each cycle.
  - When the counter reaches `WAIT_CYCLES-1`, the next state is PLAY.
  - `start_edge` is ignored.
- PLAY (2):
  - The arm counter clears on entry and saturates at `ARM_CYCLES`.
  - Landing is evaluated only when armed: `land = armed && (Ball_Y + BALL_H >= FLOOR_Y)`.
  - Landing-side sums use 13-bit arithmetic, so there is no wrap for `Ball_X`/`Ball_Y` near 4095.
  - Ball centre is `cx = Ball_X + BALL_W/2`.
  - `cx < NET_X` means the ball landed on the NPC side: player scores, `who_win` ← 0.
  - Otherwise (including `cx == NET_X`) the player side lost: NPC scores, `who_win` ← 1.
  - On `land`: the scorer's score increments, `point_pulse`=1 for one cycle, and the next state is END if the new score == `WIN_SCORE`, else WAIT.
  - Only one point is awarded per rally, because the state leaves PLAY on the same edge.
- END (3):
  - Scores and `who_win` are frozen.
  - `start_edge` moves to START. START then clears the scores, so a second edge is needed to serve.
- Scores saturate at `WIN_SCORE`. They never exceed it or wrap.
- State encoding 2'b00..2'b11 is mandatory, because the ball block decodes it directly.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- START → WAIT: `Game_state` reads 1 on the first edge after the cycle where `start_edge` is high.
- WAIT length: exactly `WAIT_CYCLES` cycles with `Game_state`=1.
- PLAY arming: `Game_state`=2 for `ARM_CYCLES` cycles before `land` can be true. This covers the ball block reloading its serve position.
- Landing latency: floor condition true in armed cycle N → at edge N+1, score, `who_win`, `point_pulse`=1 and the new state all update together. `point_pulse` returns to 0 at N+2.
- Reset asserted mid-rally: all outputs clear immediately, without waiting for `clk`. The first active edge after release sees START.

## Test plan
- Reset and start: assert `reset_n`=0 in PLAY → outputs 0 immediately. Release, hold `start_btn` high for 10 cycles → one transition to WAIT, and `Game_state`=2 after exactly `WAIT_CYCLES` cycles (bench sets `WAIT_CYCLES`=8).
- Player point: in armed PLAY, drive `Ball_X`=40, `Ball_Y`=190 → next cycle `player_score`=1, `who_win`=0, `point_pulse`=1, `Game_state`=1.
- NPC point and tie-break: `Ball_X`=145 (`cx`=160), `Ball_Y`=200 → `npc_score`+1, `who_win`=1.
- Arming guard: `Ball_Y`=220 present on the first PLAY cycle, removed by the cycle before arming → no point; a later `Ball_Y`=190 scores normally.
- Match end: player reaches 4, then lands a fifth point → `Game_state`=3 and `player_score`=5. Further `Ball_Y`=250 changes nothing. Start edge → START with scores 0; second edge → WAIT.
- Overflow: `Ball_Y`=4090, `Ball_X`=4080 in armed PLAY → NPC scores; no wrap misclassification.

Source files
------------

// File: rtl/rally_ctrl_if.sv
// Ball/controller bus: the controller publishes game state and point winner,
// the ball physics block publishes the ball position.
interface rally_ctrl_if;
    logic [11:0] Ball_X;
    logic [11:0] Ball_Y;
    logic [1:0]  Game_state;
    logic        who_win;

    modport master (input Ball_X, input Ball_Y, output Game_state, output who_win);
    modport slave  (output Ball_X, output Ball_Y, input Game_state, input who_win);
endinterface

// File: rtl/rally_ctrl.sv
// Rally/score controller: detects floor landings, awards points, and sequences
// START -> WAIT (serve delay) -> PLAY -> ... -> END.
module rally_ctrl #(
    parameter int unsigned BALL_W      = 30,
    parameter int unsigned BALL_H      = 30,
    parameter int unsigned FLOOR_Y     = 220,
    parameter int unsigned NET_X       = 160,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned WAIT_CYCLES = 50_000_000,
    parameter int unsigned ARM_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_btn,
    rally_ctrl_if.master     bus,
    output logic [3:0]       player_score,
    output logic [3:0]       npc_score,
    output logic             point_pulse
);

    typedef enum logic [1:0] {
        StStart = 2'd0,
        StWait  = 2'd1,
        StPlay  = 2'd2,
        StEnd   = 2'd3
    } state_e;

    localparam logic [12:0] BallH13   = 13'(BALL_H);
    localparam logic [12:0] HalfW13   = 13'(BALL_W / 2);
    localparam logic [12:0] FloorY13  = 13'(FLOOR_Y);
    localparam logic [12:0] NetX13    = 13'(NET_X);
    localparam logic [31:0] WaitLast  = 32'(WAIT_CYCLES - 1);
    localparam logic [7:0]  ArmMax    = 8'(ARM_CYCLES);
    localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);

    state_e      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  arm_cnt_q, arm_cnt_d;
    logic [3:0]  ps_q, ps_d, ns_q, ns_d;
    logic        who_win_q, who_win_d;
    logic        pulse_q, pulse_d;
    logic        start_prev_q;

    logic        start_edge, armed, floor_hit, npc_side, land;
    logic [3:0]  ps_inc, ns_inc;

    // 13-bit sums so positions near 4095 cannot wrap into a false result
    assign floor_hit  = ({1'b0, bus.Ball_Y} + BallH13) >= FloorY13;
    assign npc_side   = ({1'b0, bus.Ball_X} + HalfW13) < NetX13;
    assign start_edge = start_btn & ~start_prev_q;
    assign armed      = (arm_cnt_q == ArmMax);
    assign land       = (state_q == StPlay) && armed && floor_hit;
    assign ps_inc     = (ps_q >= WinScore) ? WinScore : ps_q + 4'd1;
    assign ns_inc     = (ns_q >= WinScore) ? WinScore : ns_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        arm_cnt_d  = '0;
        ps_d       = ps_q;
        ns_d       = ns_q;
        who_win_d  = who_win_q;
        pulse_d    = 1'b0;
        unique case (state_q)
            StStart: begin
                ps_d      = '0;
                ns_d      = '0;
                who_win_d = 1'b0;
                if (start_edge) state_d = StWait;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (wait_cnt_q == WaitLast) state_d = StPlay;
            end
            StPlay: begin
                arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 8'd1;
                if (land) begin
                    pulse_d = 1'b1;
                    if (npc_side) begin
                        ps_d      = ps_inc;
                        who_win_d = 1'b0;
                        state_d   = (ps_inc == WinScore) ? StEnd : StWait;
                    end else begin
                        ns_d      = ns_inc;
                        who_win_d = 1'b1;
                        state_d   = (ns_inc == WinScore) ? StEnd : StWait;
                    end
                end
            end
            StEnd: begin
                // Clear on the way out so START never shows stale scores
                if (start_edge) begin
                    state_d   = StStart;
                    ps_d      = '0;
                    ns_d      = '0;
                    who_win_d = 1'b0;
                end
            end
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StStart;
            wait_cnt_q   <= '0;
            arm_cnt_q    <= '0;
            ps_q         <= '0;
            ns_q         <= '0;
            who_win_q    <= 1'b0;
            pulse_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            arm_cnt_q    <= arm_cnt_d;
            ps_q         <= ps_d;
            ns_q         <= ns_d;
            who_win_q    <= who_win_d;
            pulse_q      <= pulse_d;
            start_prev_q <= start_btn;
        end
    end

    assign bus.Game_state = state_q;
    assign bus.who_win    = who_win_q;
    assign player_score   = ps_q;
    assign npc_score      = ns_q;
    assign point_pulse    = pulse_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Self-checking bench for rally_ctrl: scoreboard of expected point outcomes,
// one task per scenario.
module tb_rally_ctrl;

    localparam int WaitN = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_btn = 1'b0;
    logic [3:0] player_score, npc_score;
    logic       point_pulse;

    rally_ctrl_if bus ();

    rally_ctrl #(
        .WAIT_CYCLES (WaitN),
        .ARM_CYCLES  (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .bus          (bus.master),
        .player_score (player_score),
        .npc_score    (npc_score),
        .point_pulse  (point_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ps;
        int ns;
        int ww;
        int st;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;
    int exp_ps = 0;
    int exp_ns = 0;

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (bus.Game_state !== 2'(st) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.Game_state !== 2'(st)) begin
            bad++;
            $display("FAIL wait_state: Game_state=%0d required %0d", bus.Game_state, st);
        end
    endtask

    task automatic wait_armed();
        wait_state(2, 40);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic land_ball(input int x, input int y);
        exp_t e, g;
        wait_armed();
        bus.Ball_X = 12'(x);
        bus.Ball_Y = 12'(y);
        if (x + 15 < 160) begin
            exp_ps = (exp_ps < 5) ? exp_ps + 1 : 5;
            e.ww = 0;
            e.st = (exp_ps == 5) ? 3 : 1;
        end else begin
            exp_ns = (exp_ns < 5) ? exp_ns + 1 : 5;
            e.ww = 1;
            e.st = (exp_ns == 5) ? 3 : 1;
        end
        e.ps = exp_ps;
        e.ns = exp_ns;
        sb_q.push_back(e);
        @(negedge clk);
        bus.Ball_Y = 12'd0;
        total++;
        if (point_pulse !== 1'b1) begin
            bad++;
            $display("FAIL land_pulse x=%0d y=%0d: point_pulse=%b required 1", x, y, point_pulse);
        end
        g = sb_q.pop_front();
        total++;
        if (player_score !== 4'(g.ps) || npc_score !== 4'(g.ns) ||
            bus.who_win !== 1'(g.ww) || bus.Game_state !== 2'(g.st)) begin
            bad++;
            $display("FAIL land_result x=%0d y=%0d: ps=%0d ns=%0d ww=%b st=%0d required ps=%0d ns=%0d ww=%0d st=%0d",
                     x, y, player_score, npc_score, bus.who_win, bus.Game_state,
                     g.ps, g.ns, g.ww, g.st);
        end
        @(negedge clk);
        total++;
        if (point_pulse !== 1'b0) begin
            bad++;
            $display("FAIL pulse_drop: point_pulse=%b required 0", point_pulse);
        end
    endtask

    task automatic test_reset();
        bus.Ball_X = 12'd0;
        bus.Ball_Y = 12'd0;
        #3;
        total++;
        if (bus.Game_state !== 2'd0 || bus.who_win !== 1'b0 || player_score !== 4'd0 ||
            npc_score !== 4'd0 || point_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: st=%0d ww=%b ps=%0d ns=%0d pulse=%b required all 0",
                     bus.Game_state, bus.who_win, player_score, npc_score, point_pulse);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.Game_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle: Game_state=%0d required 0", bus.Game_state);
        end
    endtask

    task automatic test_start();
        int waits = 0;
        int entries = 0;
        logic [1:0] prev = 2'd0;
        for (int i = 0; i < 30; i++) begin
            start_btn = (i < 10);
            @(negedge clk);
            if (bus.Game_state == 2'd1) waits++;
            if (bus.Game_state == 2'd1 && prev != 2'd1) entries++;
            prev = bus.Game_state;
        end
        start_btn = 1'b0;
        total++;
        if (waits != WaitN) begin
            bad++;
            $display("FAIL wait_length: got %0d cycles required %0d", waits, WaitN);
        end
        total++;
        if (entries != 1) begin
            bad++;
            $display("FAIL start_once: got %0d WAIT entries required 1", entries);
        end
        total++;
        if (bus.Game_state !== 2'd2) begin
            bad++;
            $display("FAIL start_to_play: Game_state=%0d required 2", bus.Game_state);
        end
    endtask

    task automatic test_arm_guard();
        bus.Ball_X = 12'd40;
        bus.Ball_Y = 12'd220;
        wait_state(2, 40);
        @(negedge clk);
        bus.Ball_Y = 12'd0;
        repeat (3) @(negedge clk);
        total++;
        if (point_pulse !== 1'b0 || player_score !== 4'(exp_ps) || bus.Game_state !== 2'd2) begin
            bad++;
            $display("FAIL arm_guard: pulse=%b ps=%0d st=%0d required pulse=0 ps=%0d st=2",
                     point_pulse, player_score, bus.Game_state, exp_ps);
        end
        land_ball(40, 190);
    endtask

    task automatic test_match_end();
        for (int i = 0; i < 3; i++) land_ball(40, 190);
        bus.Ball_X = 12'd40;
        bus.Ball_Y = 12'd250;
        repeat (5) @(negedge clk);
        total++;
        if (bus.Game_state !== 2'd3 || player_score !== 4'd5 || npc_score !== 4'd1 ||
            bus.who_win !== 1'b0 || point_pulse !== 1'b0) begin
            bad++;
            $display("FAIL end_frozen: st=%0d ps=%0d ns=%0d ww=%b pulse=%b required st=3 ps=5 ns=1 ww=0 pulse=0",
                     bus.Game_state, player_score, npc_score, bus.who_win, point_pulse);
        end
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        total++;
        if (bus.Game_state !== 2'd0) begin
            bad++;
            $display("FAIL end_to_start: Game_state=%0d required 0", bus.Game_state);
        end
        @(negedge clk);
        total++;
        if (bus.Game_state !== 2'd0 || player_score !== 4'd0 || npc_score !== 4'd0 ||
            bus.who_win !== 1'b0) begin
            bad++;
            $display("FAIL start_cleared: st=%0d ps=%0d ns=%0d ww=%b required st=0 ps=0 ns=0 ww=0",
                     bus.Game_state, player_score, npc_score, bus.who_win);
        end
        exp_ps = 0;
        exp_ns = 0;
        bus.Ball_Y = 12'd0;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        total++;
        if (bus.Game_state !== 2'd1) begin
            bad++;
            $display("FAIL second_serve: Game_state=%0d required 1", bus.Game_state);
        end
    endtask

    task automatic test_reset_mid();
        wait_state(2, 40);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.Game_state !== 2'd0 || bus.who_win !== 1'b0 || player_score !== 4'd0 ||
            npc_score !== 4'd0 || point_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: st=%0d ww=%b ps=%0d ns=%0d pulse=%b required all 0",
                     bus.Game_state, bus.who_win, player_score, npc_score, point_pulse);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.Game_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: Game_state=%0d required 0", bus.Game_state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        land_ball(40, 190);     // player point
        land_ball(145, 200);    // cx == NET_X goes to NPC
        test_arm_guard();
        test_match_end();
        land_ball(4080, 4090);  // near-4095 positions
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
